// File: rtl/mul_sequencer_if.sv
// Operand/result handshake bundle for mul_sequencer: start/operands in, ready/busy/done/product out.
interface mul_sequencer_if #(
  parameter int unsigned N = 8
);
  logic             start;
  logic             signed_mode;
  logic [N-1:0]     multiplicand;
  logic [N-1:0]     multiplier;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output ready, busy, done, product
  );
endinterface

// File: rtl/mul_sequencer.sv
// N-bit shift-and-add multiplier with IDLE/RUN/DONE sequencer; one add/shift step per clock.
// Define MUL_SIGNED_EN to honour signed_mode (two's-complement operands); otherwise all operations are unsigned.
module mul_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic          clock,
  input  logic          nreset,
  mul_sequencer_if.slave bus
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [N:0]      a;
  logic [N-1:0]    q;
  logic [N-1:0]    m;
  logic [CW-1:0]   cnt;
  logic            done_flag;
  logic [2*N-1:0]  product;
`ifdef MUL_SIGNED_EN
  logic            sgn;
`endif

  logic [N:0]      e, s, a_nxt;
  logic [N-1:0]    q_nxt;
  logic            fill;
  logic            last_step;

  assign last_step = (cnt == '0);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    case (state)
      IDLE, DONE: begin
        bus.ready = 1'b1;
        state_nxt = bus.start ? RUN : state;
      end
      RUN: begin
        bus.busy  = 1'b1;
        state_nxt = last_step ? DONE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One step: optional add (subtract on the signed final step, which weights the sign bit negatively),
  // then shift {S,Q} right with the sign of S refilled only for signed operation.
  always_comb begin
    e    = {1'b0, m};
    s    = a;
    fill = 1'b0;
`ifdef MUL_SIGNED_EN
    if (sgn) e = {m[N-1], m};
    if (q[0]) s = (sgn && last_step) ? (a - e) : (a + e);
    fill = sgn & s[N];
`else
    if (q[0]) s = a + e;
`endif
    a_nxt = {fill, s[N:1]};
    q_nxt = {s[0], q[N-1:1]};
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      done_flag <= 1'b0;
      product   <= '0;
`ifdef MUL_SIGNED_EN
      sgn       <= 1'b0;
`endif
    end else begin
      done_flag <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a   <= '0;
            q   <= bus.multiplier;
            m   <= bus.multiplicand;
            cnt <= CNT_LOAD;
`ifdef MUL_SIGNED_EN
            sgn <= bus.signed_mode;
`endif
          end
        end
        RUN: begin
          a   <= a_nxt;
          q   <= q_nxt;
          cnt <= cnt - CW'(1);
          if (last_step) begin
            product   <= {a_nxt[N-1:0], q_nxt};
            done_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done    = done_flag;
  assign bus.product = product;
endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised and directed self-checking bench for mul_sequencer against an arithmetic product model.
module tb_mul_sequencer;
  localparam int unsigned N = 8;
  localparam int unsigned W = 2 * N;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  mul_sequencer_if #(.N(N)) bus();
  mul_sequencer #(.N(N)) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] m, input logic [N-1:0] q, input logic s);
    longint pm, pq;
    logic   eff;
`ifdef MUL_SIGNED_EN
    eff = s;
`else
    eff = 1'b0;
`endif
    pm = eff ? longint'($signed(m)) : longint'(m);
    pq = eff ? longint'($signed(q)) : longint'(q);
    return W'(pm * pq);
  endfunction

  // Call at a negedge; drives start now and returns at the negedge where done is seen.
  task automatic do_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                       input logic s, input bit scramble);
    int lat, busy_n;
    lat = 0;
    busy_n = 0;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.signed_mode  = s;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 1) begin
        bus.start = 1'b0;
        if (scramble) begin
          bus.multiplicand = N'($urandom);
          bus.multiplier   = N'($urandom);
          bus.signed_mode  = 1'($urandom);
        end
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(N + 1));
    check({tag, " busy"}, 64'(busy_n), 64'(N));
    check({tag, " product"}, 64'(bus.product), 64'(model(m, q, s)));
  endtask

  initial begin
    int dones, lat;
    logic [W-1:0] prev;
    bus.start        = 1'b1;
    bus.signed_mode  = 1'b1;
    bus.multiplicand = 8'hA5;
    bus.multiplier   = 8'h5A;

    // Reset held with arbitrary inputs
    repeat (3) @(negedge clock);
    check("rst ready", 64'(bus.ready), 64'd1);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst product", 64'(bus.product), 64'd0);
    bus.start = 1'b0;
    nreset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle ready", 64'(bus.ready), 64'd1);
    check("idle busy", 64'(bus.busy), 64'd0);
    check("idle done", 64'(bus.done), 64'd0);
    check("idle product", 64'(bus.product), 64'd0);

    // Directed unsigned
    do_op("u13x11", 8'd13, 8'd11, 1'b0, 1'b0);
    check("u13x11 val", 64'(bus.product), 64'h008F);
    @(negedge clock);
    check("done pulse width", 64'(bus.done), 64'd0);
    check("hold ready", 64'(bus.ready), 64'd1);
    repeat (3) @(negedge clock);
    check("product hold", 64'(bus.product), 64'h008F);

    // Carry case, then back-to-back with start held in DONE
    @(negedge clock);
    do_op("u255x255", 8'd255, 8'd255, 1'b0, 1'b0);
    check("u255 val", 64'(bus.product), 64'hFE01);
    do_op("b2b 0x200", 8'd0, 8'd200, 1'b0, 1'b0);

    // Signed directed
    @(negedge clock);
`ifdef MUL_SIGNED_EN
    do_op("s fd*05", 8'hFD, 8'h05, 1'b1, 1'b0);
    check("s fd*05 val", 64'(bus.product), 64'hFFF1);
    @(negedge clock);
    do_op("s 80*80", 8'h80, 8'h80, 1'b1, 1'b0);
    check("s 80*80 val", 64'(bus.product), 64'h4000);
    @(negedge clock);
    do_op("s 7f*80", 8'h7F, 8'h80, 1'b1, 1'b0);
    check("s 7f*80 val", 64'(bus.product), 64'hC080);
`else
    do_op("nosgn fd*05", 8'hFD, 8'h05, 1'b1, 1'b0);
    check("nosgn val", 64'(bus.product), 64'h04F1);
`endif

    // start and operand changes during RUN are ignored
    @(negedge clock);
    bus.start = 1'b1;
    bus.multiplicand = 8'd6;
    bus.multiplier = 8'd7;
    bus.signed_mode = 1'b0;
    dones = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin
        bus.start = 1'b1;
        bus.multiplicand = 8'd1;
        bus.multiplier = 8'd1;
        bus.signed_mode = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) dones++;
    end
    check("ignore dones", 64'(dones), 64'd1);
    check("ignore product", 64'(bus.product), 64'd42);

    // Reset during the 4th RUN cycle
    @(negedge clock);
    bus.start = 1'b1;
    bus.multiplicand = 8'd200;
    bus.multiplier = 8'd3;
    bus.signed_mode = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 1) bus.start = 1'b0;
    end
    nreset = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort ready", 64'(bus.ready), 64'd1);
    check("abort product", 64'(bus.product), 64'd0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    do_op("after abort 9x9", 8'd9, 8'd9, 1'b0, 1'b0);
    check("9x9 val", 64'(bus.product), 64'd81);

    // Randomised operations, some chained back-to-back, inputs scrambled during RUN
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) != 0) @(negedge clock);
      do_op("rand", N'($urandom), N'($urandom), 1'($urandom), 1'b1);
    end

    // Final: done must drop and product hold while idle
    prev = model(8'd0, 8'd0, 1'b0);
    @(negedge clock);
    bus.start = 1'b0;
    prev = bus.product;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.done) lat++;
    end
    check("final done quiet", 64'(lat), 64'd0);
    check("final busy", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
